// File: rtl/thor2023_ifetch_buf_pkg.sv
// Shared constants, state encoding and helpers for the Thor2023 instruction prefetch buffer.
package thor2023_ifetch_buf_pkg;

  localparam int unsigned FETCH_LINE_BYTES = 32;
  localparam int unsigned FETCH_WIN_BYTES  = 20;
  localparam int unsigned LINE_BITS        = FETCH_LINE_BYTES * 8;
  localparam int unsigned WIN_BITS         = FETCH_WIN_BYTES * 8;
  localparam logic [31:0] IFB_RSTPC        = 32'hFFFD0000;

  typedef enum logic [1:0] {
    IFB_IDLE,
    IFB_REQ,
    IFB_WAIT,
    IFB_STALE
  } ifetch_state_t;

  // Consumption never exceeds one full window.
  function automatic logic [4:0] clamp_adv(input logic [4:0] n);
    return (n > 5'(FETCH_WIN_BYTES)) ? 5'(FETCH_WIN_BYTES) : n;
  endfunction

endpackage

// File: rtl/thor2023_fetch_window.sv
// Selects the 20-byte fetch window from the head line and its successor at byte offset off.
module thor2023_fetch_window
  import thor2023_ifetch_buf_pkg::*;
(
  input  logic [2*LINE_BITS-1:0] lines,
  input  logic [4:0]             off,
  output logic [WIN_BITS-1:0]    win
);

  logic [7:0] bit_off;

  assign bit_off = {off, 3'b000};
  assign win     = lines[bit_off +: WIN_BITS];

endmodule

// File: rtl/thor2023_ifetch_buf.sv
// Sequential line prefetcher feeding decode with a byte-aligned instruction window.
module thor2023_ifetch_buf
  import thor2023_ifetch_buf_pkg::*;
#(
  parameter int unsigned     AWID  = 32,
  parameter int unsigned     DEPTH = 4,
  parameter logic [AWID-1:0] RSTPC = AWID'(IFB_RSTPC)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 req_o,
  output logic [AWID-1:0]      req_adr_o,
  input  logic                 req_ack_i,
  input  logic                 fill_v_i,
  input  logic [AWID-1:0]      fill_adr_i,
  input  logic [LINE_BITS-1:0] fill_dat_i,
  output logic                 ir_v_o,
  output logic [AWID-1:0]      ir_pc_o,
  output logic [WIN_BITS-1:0]  ir_bundle_o,
  input  logic                 adv_i,
  input  logic [4:0]           adv_cnt_i,
  input  logic                 redirect_i,
  input  logic [AWID-1:0]      redirect_pc_i
);

  localparam int unsigned HW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned VW = CW + 6;

  logic [LINE_BITS-1:0] mem [DEPTH];
  logic [HW-1:0]        head;
  logic [CW-1:0]        cnt;
  logic [AWID-1:0]      pc;
  logic [AWID-1:0]      next_adr;
  ifetch_state_t        state;

  logic [4:0]    off;
  logic [4:0]    adv_bytes_c;
  logic [5:0]    new_off_c;
  logic          adv_take_c;
  logic          pop_c;
  logic          fill_take_c;
  logic [HW-1:0] wr_slot_c;
  logic [HW-1:0] head_next_c;

  assign off         = pc[4:0];
  assign adv_bytes_c = clamp_adv(adv_cnt_i);
  assign new_off_c   = {1'b0, off} + {1'b0, adv_bytes_c};
  assign adv_take_c  = adv_i & ir_v_o & ~redirect_i;
  assign pop_c       = adv_take_c & new_off_c[5];
  assign fill_take_c = ~rst_i & ~redirect_i & (state == IFB_WAIT) & fill_v_i
                     & (fill_adr_i == next_adr);
  assign wr_slot_c   = head + HW'(cnt);
  assign head_next_c = head + HW'(1);

  // Enough buffered bytes past the current offset to cover a whole window.
  assign ir_v_o  = (VW'(cnt) << 5) >= (VW'(off) + VW'(FETCH_WIN_BYTES));
  assign ir_pc_o = pc;

  thor2023_fetch_window u_window (
    .lines ({mem[head_next_c], mem[head]}),
    .off   (off),
    .win   (ir_bundle_o)
  );

  // Line storage carries no reset; cnt gates all reads.
  always_ff @(posedge clk_i) begin
    if (fill_take_c) mem[wr_slot_c] <= fill_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc        <= RSTPC;
      cnt       <= '0;
      head      <= '0;
      req_o     <= 1'b0;
      req_adr_o <= '0;
      next_adr  <= {RSTPC[AWID-1:5], 5'd0};
      state     <= IFB_IDLE;
    end else if (redirect_i) begin
      // An in-flight request returns stale data; STALE swallows it.
      pc       <= redirect_pc_i;
      cnt      <= '0;
      next_adr <= {redirect_pc_i[AWID-1:5], 5'd0};
      req_o    <= 1'b0;
      if (state == IFB_REQ || state == IFB_WAIT) state <= IFB_STALE;
    end else begin
      if (adv_take_c) pc <= pc + AWID'(adv_bytes_c);
      if (pop_c) head <= head_next_c;
      cnt <= cnt + CW'(fill_take_c) - CW'(pop_c);
      case (state)
        IFB_IDLE: begin
          if (cnt < CW'(DEPTH)) begin
            req_o     <= 1'b1;
            req_adr_o <= next_adr;
            state     <= IFB_REQ;
          end
        end
        IFB_REQ: begin
          if (req_ack_i) begin
            req_o <= 1'b0;
            state <= IFB_WAIT;
          end
        end
        IFB_WAIT: begin
          if (fill_take_c) begin
            next_adr <= next_adr + AWID'(FETCH_LINE_BYTES);
            state    <= IFB_IDLE;
          end
        end
        IFB_STALE: begin
          if (fill_v_i) state <= IFB_IDLE;
        end
        default: state <= IFB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_thor2023_ifetch_buf.sv
// Scoreboard bench for thor2023_ifetch_buf: byte-address reference model, randomized BIU and core.
module tb_thor2023_ifetch_buf;

  localparam int unsigned AWID   = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hFFFD0000;
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_STALE = 3;

  logic         clk = 1'b0;
  logic         rst, req, req_ack, fill_v, ir_v, adv, redirect;
  logic [31:0]  req_adr, fill_adr, ir_pc, redirect_pc;
  logic [255:0] fill_dat;
  logic [159:0] ir_bundle;
  logic [4:0]   adv_cnt;

  always #5 clk = ~clk;

  thor2023_ifetch_buf #(.AWID(AWID), .DEPTH(DEPTH), .RSTPC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst), .req_o(req), .req_adr_o(req_adr), .req_ack_i(req_ack),
    .fill_v_i(fill_v), .fill_adr_i(fill_adr), .fill_dat_i(fill_dat),
    .ir_v_o(ir_v), .ir_pc_o(ir_pc), .ir_bundle_o(ir_bundle),
    .adv_i(adv), .adv_cnt_i(adv_cnt), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  typedef struct {
    logic         v;
    logic [31:0]  pc;
    logic [159:0] bundle;
    logic         req;
    logic [31:0]  req_adr;
  } exp_t;

  exp_t expq[$];
  int   checks = 0, errors = 0;

  // Reference model: bytes [line_base(pc), m_end) are buffered.
  logic [31:0] m_pc, m_end, m_req_adr;
  logic        m_req;
  int          m_phase;
  bit          model_ok = 0;

  // Simulated BIU: one outstanding fill.
  bit          pend = 0;
  logic [31:0] pend_adr;
  int          pend_dly = 0;
  int          dly_min = 0, dly_max = 3;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ {a[10:8], 5'd0};
  endfunction

  function automatic logic [255:0] line_dat(input logic [31:0] base);
    logic [255:0] d;
    for (int k = 0; k < 32; k++) d[k*8 +: 8] = mem_byte(base + 32'(k));
    return d;
  endfunction

  function automatic logic [159:0] win_bytes(input logic [31:0] pc);
    logic [159:0] w;
    for (int k = 0; k < 20; k++) w[k*8 +: 8] = mem_byte(pc + 32'(k));
    return w;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int m_lines();
    return int'((m_end - {m_pc[31:5], 5'd0}) >> 5);
  endfunction

  function automatic bit m_valid();
    return (m_lines() * 32 - int'(m_pc[4:0])) >= 20;
  endfunction

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // One clock of stimulus: record expectation, drive BIU/core inputs, advance the model.
  task automatic step(input bit r, input bit a, input int acnt, input bit rd,
                      input logic [31:0] rpc, input int bogus, input bit ack_ok,
                      input bit force_rd);
    exp_t e;
    bit   ack_now, valid;
    int   lines, eff;
    @(negedge clk);
    if (model_ok) begin
      e.v = m_valid(); e.pc = m_pc; e.bundle = win_bytes(m_pc);
      e.req = m_req; e.req_adr = m_req_adr;
      expq.push_back(e);
    end
    if (rd && !force_rd && (m_req || (pend && pend_dly == 0))) rd = 0;
    ack_now  = m_req && !pend && ack_ok;
    fill_v   = 1'b0;
    fill_adr = $urandom;
    fill_dat = rand_line();
    if (pend && pend_dly == 0) begin
      fill_v = 1'b1; fill_adr = pend_adr; fill_dat = line_dat(pend_adr); pend = 0;
    end else begin
      if (pend) pend_dly--;
      if (bogus == 2 || (bogus == 1 && m_phase != P_STALE)) begin
        fill_v   = 1'b1;
        fill_adr = m_end + 32'(32 * $urandom_range(1, 3));
      end
    end
    rst = r; adv = a; adv_cnt = 5'(acnt); redirect = rd; redirect_pc = rpc; req_ack = ack_now;
    if (ack_now) begin
      pend = 1; pend_adr = m_req_adr; pend_dly = $urandom_range(dly_min, dly_max);
    end
    lines = m_lines(); valid = m_valid(); eff = (acnt > 20) ? 20 : acnt;
    if (r) begin
      m_pc = RST_PC; m_end = {RST_PC[31:5], 5'd0}; m_req = 0; m_phase = P_IDLE; model_ok = 1;
    end else if (rd) begin
      m_pc = rpc; m_end = {rpc[31:5], 5'd0}; m_req = 0;
      if (m_phase == P_REQ || m_phase == P_WAIT) m_phase = P_STALE;
    end else begin
      case (m_phase)
        P_IDLE:  if (lines < DEPTH) begin m_req = 1; m_req_adr = m_end; m_phase = P_REQ; end
        P_REQ:   if (ack_now) begin m_req = 0; m_phase = P_WAIT; end
        P_WAIT:  if (fill_v && fill_adr == m_end) begin m_end = m_end + 32; m_phase = P_IDLE; end
        default: if (fill_v) m_phase = P_IDLE;
      endcase
      if (a && valid) m_pc = m_pc + 32'(eff);
    end
  endtask

  task automatic idle(input bit ack_ok);
    step(0, 0, 0, 0, 32'd0, 0, ack_ok, 0);
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ir_v", 160'(ir_v), 160'(e.v));
        if (e.v) begin
          chk("ir_pc", 160'(ir_pc), 160'(e.pc));
          chk("ir_bundle", ir_bundle, e.bundle);
        end
        chk("req", 160'(req), 160'(e.req));
        if (e.req) chk("req_adr", 160'(req_adr), 160'(e.req_adr));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; adv = 1'b0; adv_cnt = '0; redirect = 1'b0; redirect_pc = '0;
    req_ack = 1'b0; fill_v = 1'b0; fill_adr = '0; fill_dat = '0;
    m_pc = RST_PC; m_end = {RST_PC[31:5], 5'd0}; m_req = 0; m_req_adr = '0; m_phase = P_IDLE;

    step(1, 0, 0, 0, 32'd0, 0, 0, 0);
    step(1, 0, 0, 0, 32'd0, 0, 0, 0);
    chk("rst_ir_v", 160'(ir_v), 160'(0));
    chk("rst_req", 160'(req), 160'(0));
    chk("rst_pc", 160'(ir_pc), 160'(32'hFFFD0000));

    // First two lines after reset.
    n = 0;
    while (m_lines() < 2 && n < 60) begin idle(1); n++; end
    idle(0);
    chk("first_v", 160'(ir_v), 160'(1));
    chk("first_pc", 160'(ir_pc), 160'(32'hFFFD0000));
    chk("first_instr", 160'(ir_bundle[39:0]), 160'(40'h0403020100));

    // Advance 20, 20 then 5.
    step(0, 1, 20, 0, 32'd0, 0, 0, 0);
    step(0, 1, 20, 0, 32'd0, 0, 0, 0);
    idle(0);
    chk("adv_pc", 160'(ir_pc), 160'(32'hFFFD0028));
    chk("adv_b0", 160'(ir_bundle[7:0]), 160'(8'h28));
    chk("adv_b19", 160'(ir_bundle[159:152]), 160'(8'h3B));
    step(0, 1, 5, 0, 32'd0, 0, 0, 0);
    idle(0);
    chk("adv5_pc", 160'(ir_pc), 160'(32'hFFFD002D));

    // Redirect while a fill is outstanding.
    dly_min = 3; dly_max = 5;
    n = 0;
    while (m_phase != P_WAIT && n < 20) begin idle(1); n++; end
    step(0, 0, 0, 1, 32'h1003, 0, 1, 0);
    dly_min = 0; dly_max = 3;
    n = 0;
    while (m_lines() < 2 && n < 60) begin idle(1); n++; end
    idle(0);
    chk("redir_pc", 160'(ir_pc), 160'(32'h1003));
    chk("redir_b0", 160'(ir_bundle[7:0]), 160'(8'h03));

    // Fill to full, then pop one line from offset 12.
    n = 0;
    while (m_pc != 32'h200C && n < 20) begin step(0, 0, 0, 1, 32'h200C, 0, 1, 0); n++; end
    n = 0;
    while (!(m_lines() == DEPTH && m_phase == P_IDLE) && n < 80) begin idle(1); n++; end
    repeat (3) idle(0);
    chk("full_req", 160'(req), 160'(0));
    chk("full_v", 160'(ir_v), 160'(1));
    step(0, 1, 20, 0, 32'd0, 0, 0, 0);
    idle(0);
    idle(0);
    chk("pop_req", 160'(req), 160'(1));
    chk("pop_req_adr", 160'(req_adr), 160'(32'h2080));
    chk("pop_pc", 160'(ir_pc), 160'(32'h2020));

    // Wrong-address fill while waiting.
    dly_min = 4; dly_max = 6;
    idle(1);
    step(0, 0, 0, 0, 32'd0, 1, 0, 0);
    idle(0);
    chk("bogus_req", 160'(req), 160'(0));

    // Fill, line-crossing advance and redirect in one cycle.
    step(0, 1, 15, 0, 32'd0, 0, 0, 0);
    n = 0;
    while (!(pend && pend_dly == 0) && n < 20) begin idle(0); n++; end
    step(0, 1, 20, 1, 32'h3000, 0, 0, 1);
    idle(0);
    chk("win_v", 160'(ir_v), 160'(0));
    chk("win_pc", 160'(ir_pc), 160'(32'h3000));
    chk("win_req", 160'(req), 160'(0));
    step(0, 0, 0, 0, 32'd0, 2, 0, 0);
    dly_min = 0; dly_max = 3;

    // Randomized traffic, including resets and near-wrap redirects.
    for (int c = 0; c < 3000; c++) begin
      int ac;
      logic [31:0] rpc;
      ac  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : 5 * int'($urandom_range(0, 4));
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFA0 + 32'($urandom_range(0, 63)) : $urandom;
      step($urandom_range(0, 599) == 0, $urandom_range(0, 2) != 0, ac,
           $urandom_range(0, 39) == 0, rpc, ($urandom_range(0, 9) == 0) ? 1 : 0,
           $urandom_range(0, 2) != 0, 0);
    end
    repeat (4) idle(1);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
